spi_arb: RTL and testbench
==========================

SPI_ARB -- requirements
Module: spi_arb

Interface
REQ-001 Parameter STARVE_LIM, default 4: max consecutive inertial grants while an A2D request is pending.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 wrt_i / wrt_a  input  1 each  one-cycle transaction request from inertial (i) / A2D (a) requester.
REQ-005 cmd_i / cmd_a  input  16 each  command word, sampled in the cycle its wrt is high.
REQ-006 lck_i / lck_a  input  1 each  requester holds the bus for its next transaction.
REQ-007 done_i / done_a  output  1 each  one-cycle completion pulse to the owning requester.
REQ-008 rd_data_i / rd_data_a  output  16 each  response word per requester.
REQ-009 ovr_i / ovr_a  output  1 each  sticky flag: request dropped.
REQ-010 spi_wrt  output  1  start pulse to the shared SPI master.
REQ-011 spi_cmd  output  16  command to the SPI master.
REQ-012 spi_done  input  1  SPI master transaction-complete pulse.
REQ-013 spi_rd  input  16  SPI master response, valid with spi_done.
REQ-014 ss_sel  output  1  slave select steering (0 = inertial, 1 = A2D).
REQ-015 busy  output  1  high in XFER and RSP.

Function
REQ-016 Pending capture: wrt_x with pend_x clear sets pend_x and latches cmd_x; wrt_x with pend_x set is dropped, latched cmd_x kept, ovr_x set.
REQ-017 States IDLE, XFER, RSP; all outputs registered.
REQ-018 IDLE, no eligible pending: stay IDLE; spi_wrt=0.
REQ-019 IDLE, eligible pending: grant one requester, clear its pend, load spi_cmd and ss_sel, go to XFER.
REQ-020 spi_wrt is high only in the first XFER cycle (one cycle after the grant decision).
REQ-021 spi_cmd and ss_sel hold stable from grant until the next grant.
REQ-022 XFER: wait for spi_done; on spi_done, register spi_rd into rd_data_x of the owner and go to RSP.
REQ-023 RSP: done_x high for exactly one cycle; go to IDLE next cycle.
REQ-024 rd_data_x holds until the next done_x for that requester.
REQ-025 Request-to-spi_wrt latency is 2 cycles minimum: wrt_x in cycle N, pend in N+1, spi_wrt in N+2.
REQ-026 Priority with both pending, no lock: inertial wins unless run_cnt == STARVE_LIM, in which case A2D wins.
REQ-027 run_cnt (3 bits) increments on an inertial grant while pend_a is set, saturating at STARVE_LIM.
REQ-028 run_cnt clears on any A2D grant, and on an inertial grant with pend_a clear.
REQ-029 Lock: lck_x sampled on spi_done sets locked owner = x; while locked, only the owner is eligible and starvation is ignored.
REQ-030 Lock release: the owner's next transaction completes with lck_x low.
REQ-031 wrt_x during its own XFER/RSP is accepted as a new pending (pend_x was cleared at grant).
REQ-032 wrt_x in the same cycle as done_x is accepted.
REQ-033 wrt_i and wrt_a in the same cycle: both captured; arbitration per REQ-026.
REQ-034 spi_done outside XFER is ignored.
REQ-035 spi_wrt and spi_done never cause a second start in the same transaction.

Reset
REQ-036 rst asserted: IDLE; pend, lock, run_cnt, ovr, done, spi_wrt, busy, ss_sel = 0; spi_cmd and rd_data = 0.
REQ-037 rst mid-XFER aborts without a done pulse; the SPI master shares the same rst.
REQ-038 First grant is possible 2 cycles after rst deassertion + wrt.

Verification
REQ-039 Single inertial: wrt_i, cmd_i=16'hA5A5 -> spi_wrt 2 cycles later with spi_cmd=A5A5, ss_sel=0; spi_done with spi_rd=16'h1234 -> done_i next cycle, rd_data_i=1234, done_a stays 0.
REQ-040 Simultaneous wrt_i/wrt_a -> inertial served first, then A2D; ss_sel 0 then 1; two done pulses in order.
REQ-041 Starvation, STARVE_LIM=4: A2D pending, inertial re-requests every done -> exactly 4 inertial grants, then A2D granted, run_cnt=0.
REQ-042 Lock: lck_a=1 on A2D done, inertial pending -> A2D's next request granted before inertial; lck_a=0 at that done -> inertial next.
REQ-043 Overflow: wrt_a twice before grant (cmd 16'h0001, then 16'h0002) -> spi_cmd=0001, ovr_a=1 until rst.
REQ-044 Reset mid-XFER -> all outputs 0 asynchronously, no done pulse, clean transaction after release.

Source files
------------

// File: rtl/spi_arb.sv
// spi_arb: two-requester arbiter (inertial / A2D) in front of one shared SPI master,
// with single-entry pending capture, starvation limit and bus lock.
`default_nettype none

module spi_arb #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt_i,
  input  logic        wrt_a,
  input  logic [15:0] cmd_i,
  input  logic [15:0] cmd_a,
  input  logic        lck_i,
  input  logic        lck_a,
  output logic        done_i,
  output logic        done_a,
  output logic [15:0] rd_data_i,
  output logic [15:0] rd_data_a,
  output logic        ovr_i,
  output logic        ovr_a,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic        ss_sel,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RSP = 2'd2} state_t;

  localparam logic [2:0] LIM = 3'(STARVE_LIM);

  state_t      state_q, state_d;
  logic        pend_i_q, pend_i_d, pend_a_q, pend_a_d;
  logic [15:0] cmdl_i_q, cmdl_i_d, cmdl_a_q, cmdl_a_d;
  logic        ovr_i_q, ovr_i_d, ovr_a_q, ovr_a_d;
  logic [2:0]  run_q, run_d;
  logic        lock_q, lock_d, lown_q, lown_d;
  logic        spi_wrt_q, spi_wrt_d;
  logic [15:0] spi_cmd_q, spi_cmd_d;
  logic        ss_q, ss_d;
  logic        done_i_q, done_i_d, done_a_q, done_a_d;
  logic [15:0] rdi_q, rdi_d, rda_q, rda_d;
  logic        busy_q, busy_d;
  logic        gnt_i, gnt_a;

  always_comb begin
    state_d   = state_q;
    pend_i_d  = pend_i_q;
    pend_a_d  = pend_a_q;
    cmdl_i_d  = cmdl_i_q;
    cmdl_a_d  = cmdl_a_q;
    ovr_i_d   = ovr_i_q;
    ovr_a_d   = ovr_a_q;
    run_d     = run_q;
    lock_d    = lock_q;
    lown_d    = lown_q;
    spi_wrt_d = 1'b0;
    spi_cmd_d = spi_cmd_q;
    ss_d      = ss_q;
    done_i_d  = 1'b0;
    done_a_d  = 1'b0;
    rdi_d     = rdi_q;
    rda_d     = rda_q;
    gnt_i     = 1'b0;
    gnt_a     = 1'b0;

    if (state_q == IDLE) begin
      if (lock_q) begin
        gnt_i = !lown_q && pend_i_q;
        gnt_a = lown_q && pend_a_q;
      end else if (pend_i_q && pend_a_q) begin
        gnt_a = (run_q == LIM);
        gnt_i = (run_q != LIM);
      end else begin
        gnt_i = pend_i_q;
        gnt_a = pend_a_q;
      end
    end

    // A request arriving while one is already pending is dropped, not queued.
    if (wrt_i) begin
      if (pend_i_q) ovr_i_d = 1'b1;
      else begin
        pend_i_d = 1'b1;
        cmdl_i_d = cmd_i;
      end
    end
    if (wrt_a) begin
      if (pend_a_q) ovr_a_d = 1'b1;
      else begin
        pend_a_d = 1'b1;
        cmdl_a_d = cmd_a;
      end
    end

    case (state_q)
      IDLE: begin
        if (gnt_i || gnt_a) begin
          state_d   = XFER;
          spi_wrt_d = 1'b1;
          spi_cmd_d = gnt_a ? cmdl_a_q : cmdl_i_q;
          ss_d      = gnt_a;
          if (gnt_i) pend_i_d = 1'b0;
          if (gnt_a) pend_a_d = 1'b0;
          if (gnt_i && pend_a_q) run_d = (run_q == LIM) ? run_q : run_q + 3'd1;
          else                   run_d = 3'd0;
        end
      end
      XFER: begin
        if (spi_done) begin
          state_d = RSP;
          lown_d  = ss_q;
          if (ss_q) begin
            rda_d    = spi_rd;
            done_a_d = 1'b1;
            lock_d   = lck_a;
          end else begin
            rdi_d    = spi_rd;
            done_i_d = 1'b1;
            lock_d   = lck_i;
          end
        end
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_i_q  <= 1'b0;
      pend_a_q  <= 1'b0;
      cmdl_i_q  <= 16'h0;
      cmdl_a_q  <= 16'h0;
      ovr_i_q   <= 1'b0;
      ovr_a_q   <= 1'b0;
      run_q     <= 3'd0;
      lock_q    <= 1'b0;
      lown_q    <= 1'b0;
      spi_wrt_q <= 1'b0;
      spi_cmd_q <= 16'h0;
      ss_q      <= 1'b0;
      done_i_q  <= 1'b0;
      done_a_q  <= 1'b0;
      rdi_q     <= 16'h0;
      rda_q     <= 16'h0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_i_q  <= pend_i_d;
      pend_a_q  <= pend_a_d;
      cmdl_i_q  <= cmdl_i_d;
      cmdl_a_q  <= cmdl_a_d;
      ovr_i_q   <= ovr_i_d;
      ovr_a_q   <= ovr_a_d;
      run_q     <= run_d;
      lock_q    <= lock_d;
      lown_q    <= lown_d;
      spi_wrt_q <= spi_wrt_d;
      spi_cmd_q <= spi_cmd_d;
      ss_q      <= ss_d;
      done_i_q  <= done_i_d;
      done_a_q  <= done_a_d;
      rdi_q     <= rdi_d;
      rda_q     <= rda_d;
      busy_q    <= busy_d;
    end
  end

  assign done_i    = done_i_q;
  assign done_a    = done_a_q;
  assign rd_data_i = rdi_q;
  assign rd_data_a = rda_q;
  assign ovr_i     = ovr_i_q;
  assign ovr_a     = ovr_a_q;
  assign spi_wrt   = spi_wrt_q;
  assign spi_cmd   = spi_cmd_q;
  assign ss_sel    = ss_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_arb.sv
// tb_spi_arb: randomized requesters and SPI slave, transaction-level reference model,
// scoreboard queues for start and completion events.
`default_nettype none

module tb_spi_arb;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wrt_i = 0, wrt_a = 0, lck_i = 0, lck_a = 0, spi_done = 0;
  logic [15:0] cmd_i = 0, cmd_a = 0, spi_rd = 0;
  logic        done_i, done_a, ovr_i, ovr_a, spi_wrt, ss_sel, busy;
  logic [15:0] rd_data_i, rd_data_a, spi_cmd;

  spi_arb #(.STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .wrt_i(wrt_i), .wrt_a(wrt_a), .cmd_i(cmd_i), .cmd_a(cmd_a),
    .lck_i(lck_i), .lck_a(lck_a),
    .done_i(done_i), .done_a(done_a), .rd_data_i(rd_data_i), .rd_data_a(rd_data_a),
    .ovr_i(ovr_i), .ovr_a(ovr_a),
    .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done), .spi_rd(spi_rd),
    .ss_sel(ss_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = inertial, 1 = A2D; phase 0 idle, 1 transfer, 2 response.
  typedef struct {int who; logic [15:0] data;} ev_t;
  ev_t         q_start[$];
  ev_t         q_done[$];
  logic        m_pend[2];
  logic [15:0] m_cmd[2];
  logic        m_ovr[2];
  logic [15:0] m_rd[2];
  logic [15:0] m_scmd;
  int          m_phase, m_own, m_run, m_lown, m_ss;
  logic        m_lock, m_first;
  int          scnt;

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_pend[x] = 0; m_cmd[x] = 0; m_ovr[x] = 0; m_rd[x] = 0;
    end
    m_scmd = 0; m_phase = 0; m_own = 0; m_run = 0; m_lown = 0; m_ss = 0;
    m_lock = 0; m_first = 0;
    q_start.delete();
    q_done.delete();
  endtask

  task automatic model_step();
    logic        w[2], op[2], l[2];
    logic [15:0] c[2];
    int          g;
    w[0] = wrt_i; w[1] = wrt_a; c[0] = cmd_i; c[1] = cmd_a; l[0] = lck_i; l[1] = lck_a;
    op[0] = m_pend[0]; op[1] = m_pend[1];
    g = -1;
    m_first = 0;
    if (m_phase == 0) begin
      if (m_lock)                g = op[m_lown] ? m_lown : -1;
      else if (op[0] && op[1])   g = (m_run == LIM) ? 1 : 0;
      else if (op[0])            g = 0;
      else if (op[1])            g = 1;
    end
    for (int x = 0; x < 2; x++)
      if (w[x]) begin
        if (op[x]) m_ovr[x] = 1;
        else begin m_pend[x] = 1; m_cmd[x] = c[x]; end
      end
    if (g >= 0) begin
      m_pend[g] = 0; m_scmd = m_cmd[g]; m_ss = g; m_own = g; m_phase = 1; m_first = 1;
      q_start.push_back('{g, m_cmd[g]});
      if (g == 0 && op[1]) m_run = (m_run < LIM) ? m_run + 1 : m_run;
      else                 m_run = 0;
    end else if (m_phase == 1) begin
      if (spi_done) begin
        m_rd[m_own] = spi_rd;
        q_done.push_back('{m_own, spi_rd});
        m_lock = l[m_own]; m_lown = m_own; m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  endtask

  // One clock: model follows the edge, then slave and requesters drive new inputs.
  task automatic run_cycles(input int n, input int rate);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      spi_done = 0;
      if (spi_wrt) scnt = $urandom_range(1, 4);
      else if (scnt > 0) begin
        scnt--;
        if (scnt == 0) begin spi_done = 1; spi_rd = 16'($urandom); end
      end else if ($urandom_range(0, 15) == 0) begin
        spi_done = 1; spi_rd = 16'($urandom);
      end
      wrt_i = ($urandom_range(0, 99) < rate);
      wrt_a = ($urandom_range(0, 99) < rate);
      cmd_i = 16'($urandom);
      cmd_a = 16'($urandom);
      lck_i = ($urandom_range(0, 2) == 0);
      lck_a = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"},  {30'd0, done_i, done_a}, 32'd0);
    chk({tag, "_ovr"},   {30'd0, ovr_i, ovr_a}, 32'd0);
    chk({tag, "_ctl"},   {29'd0, spi_wrt, ss_sel, busy}, 32'd0);
    chk({tag, "_cmd"},   {16'd0, spi_cmd}, 32'd0);
    chk({tag, "_rd"},    {rd_data_i, rd_data_a}, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT starts or completes a transaction.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (spi_wrt) begin
          if (q_start.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL start_unexpected: got spi_wrt=1 expected no start at %0t", $time);
          end else begin
            e = q_start.pop_front();
            chk("start_ss_sel", {31'd0, ss_sel}, e.who);
            chk("start_cmd", {16'd0, spi_cmd}, {16'd0, e.data});
          end
        end
        if (done_i || done_a) begin
          if (q_done.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_unexpected: got done=%b%b expected none at %0t", done_i, done_a, $time);
          end else begin
            e = q_done.pop_front();
            chk("done_owner", {30'd0, done_i, done_a}, (e.who == 1) ? 32'd1 : 32'd2);
            chk("done_data", {16'd0, (e.who == 1) ? rd_data_a : rd_data_i}, {16'd0, e.data});
          end
        end
        chk("spi_wrt", {31'd0, spi_wrt}, {31'd0, m_first});
        chk("done_i", {31'd0, done_i}, (m_phase == 2 && m_own == 0) ? 32'd1 : 32'd0);
        chk("done_a", {31'd0, done_a}, (m_phase == 2 && m_own == 1) ? 32'd1 : 32'd0);
        chk("busy", {31'd0, busy}, (m_phase != 0) ? 32'd1 : 32'd0);
        chk("ss_sel", {31'd0, ss_sel}, m_ss);
        chk("spi_cmd", {16'd0, spi_cmd}, {16'd0, m_scmd});
        chk("ovr", {30'd0, ovr_i, ovr_a}, {30'd0, m_ovr[0], m_ovr[1]});
        chk("rd_data", {rd_data_i, rd_data_a}, {m_rd[0], m_rd[1]});
      end
    end
  end

  initial begin
    int t;
    scnt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 0;

    run_cycles(1500, 30);
    run_cycles(1000, 70);

    // Asynchronous reset in the middle of a transfer.
    t = 0;
    while (!(m_phase == 1 && !m_first) && t < 300) begin
      run_cycles(1, 50);
      t++;
    end
    chk("reach_mid_xfer", {31'd0, busy}, 32'd1);
    #2 rst = 1;
    wrt_i = 0; wrt_a = 0; spi_done = 0; scnt = 0;
    model_reset();
    #1 check_zero("mid_xfer_rst");
    @(negedge clk);
    @(negedge clk);
    check_zero("rst_hold");
    rst = 0;

    run_cycles(1000, 40);
    run_cycles(40, 0);
    chk("start_q_drained", q_start.size(), 32'd0);
    chk("done_q_drained", q_done.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
